// File: rtl/codificador_mensagem_pkg.sv
// Shared types and helpers for the message encoder: display codes, FSM
// encodings and the lowest-index-first priority encoder.
package codificador_mensagem_pkg;

  `include "codigos_display.vh"

  localparam int N_COD = 15;

  typedef struct packed {
    logic       any;
    logic [3:0] code;
  } prio_t;

  // Lowest set index wins; code stays blank when nothing is pending.
  function automatic prio_t prioridade(input logic [N_COD-1:0] p);
    prio_t r;
    r.any  = |p;
    r.code = COD_BRANCO;
    for (int i = N_COD - 1; i >= 0; i--) begin
      if (p[i]) r.code = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [N_COD-1:0] um_quente(input logic [3:0] c);
    logic [N_COD-1:0] um;
    um = {{(N_COD-1){1'b0}}, 1'b1};
    return um << c;
  endfunction

endpackage

// File: rtl/codigos_display.vh
// Display-code values and FSM state encodings shared by the code producer,
// the display decoder and their benches.
`ifndef CODIGOS_DISPLAY_VH
`define CODIGOS_DISPLAY_VH

localparam logic [3:0] COD_BRANCO = 4'b1111;
localparam logic [3:0] COD_0      = 4'd0;
localparam logic [3:0] COD_1      = 4'd1;
localparam logic [3:0] COD_2      = 4'd2;
localparam logic [3:0] COD_3      = 4'd3;
localparam logic [3:0] COD_4      = 4'd4;
localparam logic [3:0] COD_5      = 4'd5;
localparam logic [3:0] COD_6      = 4'd6;
localparam logic [3:0] COD_7      = 4'd7;
localparam logic [3:0] COD_8      = 4'd8;
localparam logic [3:0] COD_9      = 4'd9;
localparam logic [3:0] COD_10     = 4'd10;
localparam logic [3:0] COD_11     = 4'd11;
localparam logic [3:0] COD_12     = 4'd12;
localparam logic [3:0] COD_13     = 4'd13;
localparam logic [3:0] COD_14     = 4'd14;

localparam logic [1:0] EST_IDLE = 2'd0;
localparam logic [1:0] EST_SHOW = 2'd1;
localparam logic [1:0] EST_GAP  = 2'd2;

`endif

// File: rtl/contador_tempo.sv
// Up-counter with synchronous clear and enable; flags when the current value
// equals the terminal-count input and exposes its next value for look-ahead.
module contador_tempo #(
  parameter int CNT_W = 26
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limite,
  output logic [CNT_W-1:0] valor_prox,
  output logic             terminal
);

  logic [CNT_W-1:0] valor_q;
  logic [CNT_W-1:0] valor_d;

  always_comb begin
    valor_d = valor_q;
    if (clr) begin
      valor_d = '0;
    end else if (en) begin
      valor_d = valor_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    valor_q <= valor_d;
  end

  assign valor_prox = valor_d;
  assign terminal   = (valor_q == limite);

endmodule

// File: rtl/codificador_mensagem.sv
// Producer of the 4-bit display-code stream: queues one-cycle requests, holds
// each code for HOLD_CYCLES, blanks for GAP_CYCLES, serves lowest code first.
module codificador_mensagem
  import codificador_mensagem_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_W       = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] req,
  input  logic        clear,
  output logic [3:0]  bits,
  output logic        ativo,
  output logic        fim
);

  localparam logic [CNT_W-1:0] LIM_HOLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_GAP  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit               TEM_GAP  = (GAP_CYCLES > 0);

  logic [1:0]       state_q, state_d;
  logic [14:0]      pend_q, pend_d;
  logic [3:0]       bits_q, bits_d;
  logic             fim_q, fim_d;

  prio_t            prio;
  logic [14:0]      taken;
  logic             carrega;
  logic             tmr_clr, tmr_en;
  logic [CNT_W-1:0] tmr_lim, tmr_prox;
  logic             tmr_tc;

  contador_tempo #(
    .CNT_W(CNT_W)
  ) u_tempo (
    .clock      (clock),
    .clr        (tmr_clr | reset),
    .en         (tmr_en),
    .limite     (tmr_lim),
    .valor_prox (tmr_prox),
    .terminal   (tmr_tc)
  );

  always_comb begin
    prio    = prioridade(pend_q);
    state_d = state_q;
    bits_d  = bits_q;
    taken   = '0;
    carrega = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tmr_lim = (state_q == EST_SHOW) ? LIM_HOLD : LIM_GAP;

    case (state_q)
      EST_IDLE: begin
        bits_d  = COD_BRANCO;
        tmr_clr = 1'b1;
        carrega = prio.any;
      end
      EST_SHOW: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (TEM_GAP) begin
            state_d = EST_GAP;
            bits_d  = COD_BRANCO;
          end else if (prio.any) begin
            carrega = 1'b1;
          end else begin
            state_d = EST_IDLE;
            bits_d  = COD_BRANCO;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      EST_GAP: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (prio.any) begin
            carrega = 1'b1;
          end else begin
            state_d = EST_IDLE;
            bits_d  = COD_BRANCO;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d = EST_IDLE;
        bits_d  = COD_BRANCO;
        tmr_clr = 1'b1;
      end
    endcase

    if (carrega) begin
      state_d = EST_SHOW;
      bits_d  = prio.code;
      taken   = um_quente(prio.code);
      tmr_clr = 1'b1;
    end

    // A request for the code being loaded survives, so it is shown again later.
    pend_d = (pend_q & ~taken) | req;

    if (clear) begin
      state_d = EST_IDLE;
      bits_d  = COD_BRANCO;
      pend_d  = '0;
      tmr_clr = 1'b1;
      tmr_en  = 1'b0;
    end
  end

  // fim is registered from the look-ahead timer value so it marks the last SHOW cycle.
  always_comb begin
    fim_d = (state_d == EST_SHOW) && (tmr_prox == LIM_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EST_IDLE;
      pend_q  <= '0;
      bits_q  <= COD_BRANCO;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bits_q  <= bits_d;
      fim_q   <= fim_d;
    end
  end

  assign bits  = bits_q;
  assign ativo = (state_q == EST_SHOW);
  assign fim   = fim_q;

endmodule

// File: tb/tb_codificador_mensagem.sv
// Directed bench for codificador_mensagem: one instance with a blank gap and
// one without, checked cycle by cycle against hand-built expected streams.
module tb_codificador_mensagem;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int CW   = 3;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear, reset0, clear0;
  logic [14:0] req, req0;
  logic [3:0]  bits, bits0;
  logic        ativo, ativo0, fim, fim0;

  codificador_mensagem #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clock (clock), .reset (reset), .req (req), .clear (clear),
    .bits  (bits),  .ativo (ativo), .fim (fim)
  );

  codificador_mensagem #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .CNT_W(CW)) dut0 (
    .clock (clock), .reset (reset0), .req (req0), .clear (clear0),
    .bits  (bits0), .ativo (ativo0), .fim (fim0)
  );

  initial begin
    assert ((HOLD - 1) < (1 << CW) && (GAP - 1) < (1 << CW))
      else $error("timer width CNT_W=%0d too small for HOLD=%0d GAP=%0d", CW, HOLD, GAP);
  end

  // scoreboard: expected {fim, ativo, bits} per cycle
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got fim=%b ativo=%b bits=%h, expected fim=%b ativo=%b bits=%h",
               tag, obs[5], obs[4], obs[3:0], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_code(input logic [3:0] c, input int n, input bit com_fim);
    for (int i = 0; i < n; i++) exp_q.push_back({com_fim && (i == n - 1), 1'b1, c});
  endtask

  task automatic push_blank(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, 4'hF});
  endtask

  // driver: r0 in cycle 0, slot a (req/clear) at at_a, reset pulse at at_b
  task automatic drain(input bit sel, input string tag, input logic [14:0] r0,
                       input int at_a, input logic [14:0] req_a, input logic clr_a,
                       input int at_b);
    int i = 0;
    while (exp_q.size() > 0) begin
      logic [5:0]  e;
      logic [5:0]  obs;
      logic [14:0] r;
      logic        c, rs;
      e   = exp_q.pop_front();
      obs = sel ? {fim0, ativo0, bits0} : {fim, ativo, bits};
      chk($sformatf("%s[%0d]", tag, i), obs, e);
      r  = (i == 0) ? r0 : ((i == at_a) ? req_a : 15'h0);
      c  = (i == at_a) ? clr_a : 1'b0;
      rs = (i == at_b);
      if (sel) begin
        req0 = r; clear0 = c; reset0 = rs;
      end else begin
        req = r; clear = c; reset = rs;
      end
      step();
      i++;
    end
    req = '0; clear = 1'b0; reset = 1'b0;
    req0 = '0; clear0 = 1'b0; reset0 = 1'b0;
  endtask

  initial begin
    req = '0; clear = 1'b0; reset = 1'b1;
    req0 = '0; clear0 = 1'b0; reset0 = 1'b1;
    repeat (3) step();
    chk("reset", {fim, ativo, bits}, 6'h0F);
    chk("reset_nogap", {fim0, ativo0, bits0}, 6'h0F);
    reset = 1'b0; reset0 = 1'b0;

    push_blank(10);
    drain(1'b0, "idle", 15'h0, -1, 15'h0, 1'b0, -1);

    push_blank(2); push_code(4'h9, 4, 1'b1); push_blank(4);
    drain(1'b0, "single", 15'h0200, -1, 15'h0, 1'b0, -1);

    push_blank(2); push_code(4'h0, 4, 1'b1); push_blank(2);
    push_code(4'hB, 4, 1'b1); push_blank(2);
    push_code(4'hE, 4, 1'b1); push_blank(4);
    drain(1'b0, "simult", 15'h4801, -1, 15'h0, 1'b0, -1);

    push_blank(2); push_code(4'h3, 4, 1'b1); push_blank(2);
    push_code(4'h3, 4, 1'b1); push_blank(4);
    drain(1'b0, "rereq", 15'h0008, 3, 15'h0008, 1'b0, -1);

    push_blank(2); push_code(4'h4, 2, 1'b0); push_blank(12);
    drain(1'b0, "clear", 15'h0090, 3, 15'h0020, 1'b1, -1);

    push_blank(2); push_code(4'h1, 4, 1'b1); push_code(4'h2, 4, 1'b1); push_blank(3);
    drain(1'b1, "nogap", 15'h0002, 1, 15'h0004, 1'b0, -1);

    push_blank(2); push_code(4'h1, 3, 1'b0); push_blank(8);
    drain(1'b1, "midreset", 15'h0002, 1, 15'h0004, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
